// File: rtl/projeto_processador.sv
// Multicycle 16-bit lab CPU: one ROM instruction per run pulse, executed over T1..T3
// through a single shared bus into registers r0..r7, accumulator A, ALU result G and data RAM.
module projeto_processador #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter logic [2**ADDR_W-1:0][DATA_W-1:0] ROM_INIT =
    {{27{16'h0000}}, 16'h8001, 16'hA001, 16'h5209, 16'h8200, 16'h1004}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Din,
  input  logic              run,
  output logic              done
);

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_OPND, SEL_MVT, SEL_RX, SEL_G, SEL_MEM} bus_sel_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;

  tstep_t                   tstep_q, tstep_d;
  bus_sel_t                 bus_sel;
  logic [DATA_W-1:0]        ir, a, g, alu, bus_wires, operand, ram_q;
  logic [ADDR_W-1:0]        addr;
  logic [7:0][DATA_W-1:0]   regs;
  logic                     ir_ld, a_ld, g_ld, addr_ld, rx_we, ram_we;

  // RAM content survives reset; only the power-up image is fixed here
  logic [DATA_W-1:0] ram [2**ADDR_W] = '{4: DATA_W'(7), default: '0};

  logic [2:0] op, rx, ry;
  logic       imm;
  logic [8:0] imm9;

  assign op      = ir[15:13];
  assign imm     = ir[12];
  assign rx      = ir[11:9];
  assign imm9    = ir[8:0];
  assign ry      = ir[2:0];
  assign operand = imm ? {{(DATA_W-9){1'b0}}, imm9} : regs[ry];

  always_comb begin
    bus_wires = '0;
    case (bus_sel)
      SEL_OPND: bus_wires = operand;
      SEL_MVT:  bus_wires = {ir[7:0], 8'h00};
      SEL_RX:   bus_wires = regs[rx];
      SEL_G:    bus_wires = g;
      SEL_MEM:  bus_wires = ram_q;
      default:  bus_wires = '0;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = a + bus_wires;
      OP_SUB:  alu = a - bus_wires;
      OP_AND:  alu = a & bus_wires;
      default: alu = '0;
    endcase
  end

  always_comb begin
    tstep_d = tstep_q;
    bus_sel = SEL_NONE;
    done    = 1'b0;
    ir_ld   = 1'b0;
    a_ld    = 1'b0;
    g_ld    = 1'b0;
    addr_ld = 1'b0;
    rx_we   = 1'b0;
    ram_we  = 1'b0;
    case (tstep_q)
      T0: if (run) begin
        ir_ld   = 1'b1;
        tstep_d = T1;
      end
      T1: case (op)
        OP_MV: begin
          bus_sel = SEL_OPND; rx_we = 1'b1; done = 1'b1; tstep_d = T0;
        end
        OP_MVT: begin
          bus_sel = SEL_MVT; rx_we = 1'b1; done = 1'b1; tstep_d = T0;
        end
        OP_ADD, OP_SUB, OP_AND: begin
          bus_sel = SEL_RX; a_ld = 1'b1; tstep_d = T2;
        end
        OP_LD, OP_ST: begin
          addr_ld = 1'b1; tstep_d = T2;
        end
        default: begin
          done = 1'b1; tstep_d = T0;
        end
      endcase
      T2: case (op)
        OP_ADD, OP_SUB, OP_AND: begin
          bus_sel = SEL_OPND; g_ld = 1'b1; tstep_d = T3;
        end
        OP_LD: tstep_d = T3;  // RAM read register fills this cycle
        OP_ST: begin
          bus_sel = SEL_RX; ram_we = 1'b1; done = 1'b1; tstep_d = T0;
        end
        default: tstep_d = T0;
      endcase
      T3: begin
        bus_sel = (op == OP_LD) ? SEL_MEM : SEL_G;
        rx_we   = 1'b1;
        done    = 1'b1;
        tstep_d = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tstep_q <= T0;
      ir      <= '0;
      a       <= '0;
      g       <= '0;
      addr    <= '0;
      regs    <= '0;
    end else begin
      tstep_q <= tstep_d;
      if (ir_ld)   ir   <= ROM_INIT[Din];
      if (a_ld)    a    <= bus_wires;
      if (g_ld)    g    <= alu;
      if (addr_ld) addr <= regs[ry][ADDR_W-1:0];
      if (rx_we)   regs[rx] <= bus_wires;
    end
  end

  // ram_we is decoded from the async-reset state, so reset can never leave a partial write
  always_ff @(posedge clock) begin
    if (ram_we) ram[addr] <= bus_wires;
    ram_q <= ram[addr];
  end

endmodule

// File: tb/tb_projeto_processador.sv
// Bench for projeto_processador: default-ROM core plus a second core with an ALU-focused ROM.
module tb_projeto_processador;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, run2 = 1'b0;
  logic [4:0] din = '0, din2 = '0;
  logic       done, done2;
  int         checks = 0, errors = 0;

  typedef struct { int rd; logic [15:0] val; int lat; } exp_t;
  exp_t sb[$];

  localparam logic [31:0][15:0] ROM2 = {{24{16'h0000}}, 16'h4603, 16'h1603, 16'hE000,
    16'hD4F0, 16'h7401, 16'h5201, 16'h52FF, 16'h22FF};

  always #5 clock = ~clock;

  projeto_processador dut (.clock(clock), .reset(reset), .Din(din), .run(run), .done(done));
  projeto_processador #(.ROM_INIT(ROM2)) dut2 (.clock(clock), .reset(reset), .Din(din2),
    .run(run2), .done(done2));

  task automatic fire(input bit sel, input logic [4:0] adr);
    if (sel) begin din2 = adr; run2 = 1'b1; end
    else begin din = adr; run = 1'b1; end
    @(posedge clock); #1;
    run = 1'b0; run2 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int cyc);
    cyc = 1;
    while (((sel ? done2 : done) !== 1'b1) && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (dut.tstep_q !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", dut.tstep_q); end
    checks++; if (dut.regs !== '0 || dut.ir !== 16'h0) begin errors++; $display("FAIL rst_regs got %h ir %h want 0", dut.regs, dut.ir); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (dut.tstep_q !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL idle_state got %0d done %b want 0 0", dut.tstep_q, done); end
    checks++; if (dut.regs !== '0) begin errors++; $display("FAIL idle_regs got %h want 0", dut.regs); end
  endtask

  task automatic test_mv;
    exp_t e;
    sb.push_back('{0, 16'h0004, 1});
    @(negedge clock);
    fire(0, 5'd0);
    e = sb.pop_front();
    checks++; if (dut.ir !== 16'h1004) begin errors++; $display("FAIL mv_ir got %h want 1004", dut.ir); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mv_done got %b want 1", done); end
    @(posedge clock); #1;
    checks++; if (dut.regs[e.rd] !== e.val) begin errors++; $display("FAIL mv_r0 got %h want %h", dut.regs[e.rd], e.val); end
    checks++; if (dut.tstep_q !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL mv_back got %0d done %b want 0 0", dut.tstep_q, done); end
  endtask

  task automatic test_ld;
    exp_t e; int cyc;
    sb.push_back('{1, 16'h0007, 3});
    @(negedge clock);
    fire(0, 5'd1);
    wait_done(0, cyc);
    e = sb.pop_front();
    checks++; if (cyc !== e.lat) begin errors++; $display("FAIL ld_latency got %0d want %0d", cyc, e.lat); end
    checks++; if (dut.tstep_q !== 2'd3) begin errors++; $display("FAIL ld_done_step got %0d want 3", dut.tstep_q); end
    @(posedge clock); #1;
    checks++; if (dut.regs[e.rd] !== e.val) begin errors++; $display("FAIL ld_r1 got %h want %h", dut.regs[e.rd], e.val); end
  endtask

  task automatic test_add;
    exp_t e;
    sb.push_back('{1, 16'h0010, 3});
    @(negedge clock);
    fire(0, 5'd2);
    checks++; if (dut.tstep_q !== 2'd1 || done !== 1'b0) begin errors++; $display("FAIL add_t1 got %0d done %b want 1 0", dut.tstep_q, done); end
    @(posedge clock); #1;
    checks++; if (dut.a !== 16'h0007 || done !== 1'b0) begin errors++; $display("FAIL add_a got %h done %b want 0007 0", dut.a, done); end
    @(posedge clock); #1;
    e = sb.pop_front();
    checks++; if (dut.g !== e.val || done !== 1'b1 || dut.tstep_q !== 2'd3) begin errors++; $display("FAIL add_g got %h done %b step %0d want %h 1 3", dut.g, done, dut.tstep_q, e.val); end
    @(posedge clock); #1;
    checks++; if (dut.regs[e.rd] !== e.val) begin errors++; $display("FAIL add_r1 got %h want %h", dut.regs[e.rd], e.val); end
  endtask

  task automatic test_st_ld;
    exp_t e; int cyc;
    sb.push_back('{-1, 16'h0004, 2});
    sb.push_back('{0, 16'h0004, 3});
    @(negedge clock);
    fire(0, 5'd3);
    wait_done(0, cyc);
    e = sb.pop_front();
    checks++; if (cyc !== e.lat || dut.tstep_q !== 2'd2) begin errors++; $display("FAIL st_latency got %0d step %0d want %0d 2", cyc, dut.tstep_q, e.lat); end
    @(posedge clock); #1;
    checks++; if (dut.ram[16] !== e.val) begin errors++; $display("FAIL st_ram16 got %h want %h", dut.ram[16], e.val); end
    fire(0, 5'd4);
    wait_done(0, cyc);
    e = sb.pop_front();
    checks++; if (cyc !== e.lat) begin errors++; $display("FAIL ld2_latency got %0d want %0d", cyc, e.lat); end
    @(posedge clock); #1;
    checks++; if (dut.regs[e.rd] !== e.val) begin errors++; $display("FAIL ld2_r0 got %h want %h", dut.regs[e.rd], e.val); end
  endtask

  task automatic test_reset_mid;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    fire(0, 5'd2);
    @(posedge clock); #1;
    checks++; if (dut.tstep_q !== 2'd2) begin errors++; $display("FAIL mid_pre got %0d want 2", dut.tstep_q); end
    reset = 1'b1; #1;
    checks++; if (dut.tstep_q !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL mid_async got %0d done %b want 0 0", dut.tstep_q, done); end
    @(posedge clock); #1;
    checks++; if (dut.regs[1] !== 16'h0 || dut.g !== 16'h0 || dut.ram[16] !== 16'h0004) begin errors++; $display("FAIL mid_state r1 %h g %h ram16 %h want 0 0 0004", dut.regs[1], dut.g, dut.ram[16]); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_alu;
    exp_t e; int cyc;
    sb.push_back('{1, 16'hFF00, 1});
    sb.push_back('{1, 16'hFFFF, 3});
    sb.push_back('{1, 16'h0000, 3});
    sb.push_back('{2, 16'hFFFF, 3});
    sb.push_back('{2, 16'h00F0, 3});
    sb.push_back('{-1, 16'h0000, 1});
    sb.push_back('{3, 16'h0003, 1});
    sb.push_back('{3, 16'h0006, 3});
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      fire(1, 5'(i));
      wait_done(1, cyc);
      e = sb.pop_front();
      checks++; if (cyc !== e.lat) begin errors++; $display("FAIL alu%0d_latency got %0d want %0d", i, cyc, e.lat); end
      @(posedge clock); #1;
      if (e.rd >= 0) begin
        checks++; if (dut2.regs[e.rd] !== e.val) begin errors++; $display("FAIL alu%0d_r%0d got %h want %h", i, e.rd, dut2.regs[e.rd], e.val); end
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    sb.push_back('{3, 16'h0003, 1});
    sb.push_back('{3, 16'h0006, 3});
    @(negedge clock);
    din2 = 5'd6; run2 = 1'b1;
    @(negedge clock); din2 = 5'd7;
    @(posedge clock); #1;
    e = sb.pop_front();
    checks++; if (dut2.tstep_q !== 2'd0 || dut2.regs[e.rd] !== e.val) begin errors++; $display("FAIL b2b_mv step %0d r3 %h want 0 %h", dut2.tstep_q, dut2.regs[e.rd], e.val); end
    @(posedge clock); #1;
    checks++; if (dut2.tstep_q !== 2'd1 || dut2.ir !== 16'h4603) begin errors++; $display("FAIL b2b_fetch step %0d ir %h want 1 4603", dut2.tstep_q, dut2.ir); end
    @(posedge clock); #1;
    checks++; if (dut2.tstep_q !== 2'd2) begin errors++; $display("FAIL b2b_ignore step %0d want 2", dut2.tstep_q); end
    @(posedge clock); #1;
    run2 = 1'b0;
    @(posedge clock); #1;
    e = sb.pop_front();
    checks++; if (dut2.regs[e.rd] !== e.val || dut2.tstep_q !== 2'd0) begin errors++; $display("FAIL b2b_add r3 %h step %0d want %h 0", dut2.regs[e.rd], dut2.tstep_q, e.val); end
    @(posedge clock); #1;
    checks++; if (dut2.tstep_q !== 2'd0) begin errors++; $display("FAIL b2b_idle step %0d want 0", dut2.tstep_q); end
  endtask

  initial begin
    test_reset;
    test_mv;
    test_ld;
    test_add;
    test_st_ld;
    test_reset_mid;
    test_alu;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
